// File: rtl/cla_share_arbiter.sv
// Shares one carry-lookahead adder among N_REQ requesters through a round-robin arbiter.
// Granted operands are registered, added, and returned with the owner ID over valid/ready.

module param_cla #(
    parameter int WIDTH2 = 8
) (
    input  logic [WIDTH2-1:0] a_pi,
    input  logic [WIDTH2-1:0] b_pi,
    output logic [WIDTH2-1:0] sum_po
);
    logic [WIDTH2-1:0] gen_s;
    logic [WIDTH2-1:0] prop_s;
    logic [WIDTH2-1:0] carry_s;
    logic              term_s;

    assign gen_s  = a_pi & b_pi;
    assign prop_s = a_pi ^ b_pi;

    // Each carry is a flat sum-of-products of lower generate terms and the propagates above them.
    always_comb begin
        carry_s = '0;
        term_s  = 1'b0;
        for (int i = 1; i < WIDTH2; i++) begin
            for (int j = 0; j < i; j++) begin
                term_s = gen_s[j];
                for (int k = j + 1; k < i; k++) begin
                    term_s = term_s & prop_s[k];
                end
                carry_s[i] = carry_s[i] | term_s;
            end
        end
    end

    assign sum_po = prop_s ^ carry_s;
endmodule

module cla_share_arbiter #(
    parameter int WIDTH = 8,
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                   clk_pi,
    input  logic                   rst_pi,
    input  logic [N_REQ-1:0]       req_pi,
    input  logic [N_REQ*WIDTH-1:0] a_pi,
    input  logic [N_REQ*WIDTH-1:0] b_pi,
    output logic [N_REQ-1:0]       gnt_po,
    output logic [WIDTH-1:0]       result_po,
    output logic                   carry_po,
    output logic [ID_W-1:0]        result_id_po,
    output logic                   result_valid_po,
    input  logic                   result_ready_pi,
    output logic                   busy_po
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [WIDTH-1:0]  op_a_q, op_a_d;
    logic [WIDTH-1:0]  op_b_q, op_b_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic              carry_q, carry_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;

    logic              win_found_s;
    logic [ID_W-1:0]   win_idx_s;
    logic [WIDTH-1:0]  win_a_s;
    logic [WIDTH-1:0]  win_b_s;
    logic [N_REQ-1:0]  win_onehot_s;
    logic [WIDTH-1:0]  sum_s;

    param_cla #(.WIDTH2(WIDTH)) u_cla (
        .a_pi   (op_a_q),
        .b_pi   (op_b_q),
        .sum_po (sum_s)
    );

    // Lowest requester at or above ptr wins; if none, the lowest overall wins (wrap-around).
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_pi[i]) begin
                win_found_s = 1'b1;
                win_idx_s   = ID_W'(i);
            end else begin
                win_idx_s   = win_idx_s;
            end
        end
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_pi[i] && (ID_W'(i) >= ptr_q)) begin
                win_idx_s = ID_W'(i);
            end else begin
                win_idx_s = win_idx_s;
            end
        end
    end

    // Operand slice and one-hot grant for the winning requester.
    always_comb begin
        win_a_s      = '0;
        win_b_s      = '0;
        win_onehot_s = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win_idx_s == ID_W'(i)) begin
                win_a_s         = a_pi[i*WIDTH +: WIDTH];
                win_b_s         = b_pi[i*WIDTH +: WIDTH];
                win_onehot_s[i] = 1'b1;
            end else begin
                win_onehot_s[i] = 1'b0;
            end
        end
    end

    // Next-state and next-output computation for the IDLE/ADD/RESP sequence.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        gnt_d    = '0;
        result_d = result_q;
        carry_d  = carry_q;
        id_d     = id_q;
        valid_d  = valid_q;
        case (state_q)
            IDLE: begin
                if (win_found_s) begin
                    state_d = ADD;
                    op_a_d  = win_a_s;
                    op_b_d  = win_b_s;
                    id_d    = win_idx_s;
                    gnt_d   = win_onehot_s;
                    if (win_idx_s == ID_W'(N_REQ - 1)) begin
                        ptr_d = '0;
                    end else begin
                        ptr_d = win_idx_s + ID_W'(1);
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ADD: begin
                state_d  = RESP;
                result_d = sum_s;
                // A wrapped unsigned sum is always smaller than either operand.
                carry_d  = (sum_s < op_a_q);
                valid_d  = 1'b1;
            end
            RESP: begin
                if (result_ready_pi) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and registered outputs, cleared by the synchronous reset.
    always_ff @(posedge clk_pi) begin
        if (rst_pi) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            gnt_q    <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            id_q     <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            gnt_q    <= gnt_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            id_q     <= id_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
        end
    end

    assign gnt_po          = gnt_q;
    assign result_po       = result_q;
    assign carry_po        = carry_q;
    assign result_id_po    = id_q;
    assign result_valid_po = valid_q;
    assign busy_po         = busy_q;
endmodule

// File: tb/tb_cla_share_arbiter.sv
// Randomized and directed bench for cla_share_arbiter with a queue-based scoreboard
// fed by a transaction-level reference model.

module tb_cla_share_arbiter;
    localparam int W  = 8;
    localparam int N  = 4;
    localparam int IW = 2;

    logic           clk_pi = 1'b0;
    logic           rst_pi;
    logic [N-1:0]   req_pi;
    logic [N*W-1:0] a_pi;
    logic [N*W-1:0] b_pi;
    logic [N-1:0]   gnt_po;
    logic [W-1:0]   result_po;
    logic           carry_po;
    logic [IW-1:0]  result_id_po;
    logic           result_valid_po;
    logic           result_ready_pi;
    logic           busy_po;

    cla_share_arbiter #(.WIDTH(W), .N_REQ(N), .ID_W(IW)) dut (
        .clk_pi          (clk_pi),
        .rst_pi          (rst_pi),
        .req_pi          (req_pi),
        .a_pi            (a_pi),
        .b_pi            (b_pi),
        .gnt_po          (gnt_po),
        .result_po       (result_po),
        .carry_po        (carry_po),
        .result_id_po    (result_id_po),
        .result_valid_po (result_valid_po),
        .result_ready_pi (result_ready_pi),
        .busy_po         (busy_po)
    );

    always #5 clk_pi = ~clk_pi;

    typedef struct {
        int id;
        int sum;
        int carry;
    } exp_t;

    exp_t         sb_q[$];
    int           gnt_log[$];
    int           gnt_cyc[$];
    int           n_checks = 0;
    int           n_fail = 0;
    int           n_results = 0;
    int           cyc_cnt = 0;
    logic [W-1:0] last_sum;
    logic         last_carry;
    logic [IW-1:0] last_id;

    bit           pend [N];
    logic [W-1:0] opa [N];
    logic [W-1:0] opb [N];
    bit           keep = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: reference model of arbitration/latency plus scoreboard comparison.
    initial begin : monitor
        bit           armed;
        bit           prev_rst;
        int           mode;
        int           mptr;
        int           w;
        int           s;
        logic [N-1:0] exp_gnt;
        exp_t         e;
        armed = 1'b0; prev_rst = 1'b0; mode = 0; mptr = 0; exp_gnt = '0;
        forever begin
            @(negedge clk_pi);
            cyc_cnt++;
            for (int i = 0; i < N; i++) begin
                if (gnt_po[i] === 1'b1) begin
                    gnt_log.push_back(i);
                    gnt_cyc.push_back(cyc_cnt);
                end
            end
            if (prev_rst) begin
                check("rst_gnt", gnt_po, 0);
                check("rst_result", result_po, 0);
                check("rst_carry", carry_po, 0);
                check("rst_id", result_id_po, 0);
                check("rst_valid", result_valid_po, 0);
                check("rst_busy", busy_po, 0);
            end else if (armed) begin
                check("gnt", gnt_po, exp_gnt);
                check("busy", busy_po, mode != 0);
                check("valid", result_valid_po, mode == 2);
                if (mode == 2) begin
                    if (sb_q.size() == 0) begin
                        check("sb_underflow", 1, 0);
                    end else begin
                        check("result", result_po, sb_q[0].sum);
                        check("carry", carry_po, sb_q[0].carry);
                        check("result_id", result_id_po, sb_q[0].id);
                    end
                end
            end
            exp_gnt = '0;
            if (rst_pi) begin
                mode = 0; mptr = 0; sb_q.delete(); armed = 1'b1;
            end else if (armed) begin
                if (mode == 0) begin
                    if (req_pi != '0) begin
                        w = -1;
                        for (int k = 0; k < N; k++) begin
                            int c;
                            c = (mptr + k) % N;
                            if (w < 0 && req_pi[c]) w = c;
                        end
                        s = int'(a_pi[w*W +: W]) + int'(b_pi[w*W +: W]);
                        e.id = w; e.sum = s % (1 << W); e.carry = s / (1 << W);
                        sb_q.push_back(e);
                        exp_gnt[w] = 1'b1;
                        mptr = (w + 1) % N;
                        mode = 1;
                    end
                end else if (mode == 1) begin
                    mode = 2;
                end else if (result_ready_pi) begin
                    last_sum = result_po; last_carry = carry_po; last_id = result_id_po;
                    n_results++;
                    if (sb_q.size() > 0) void'(sb_q.pop_front());
                    mode = 0;
                end
            end
            prev_rst = rst_pi;
        end
    end

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_pi[i] = pend[i];
            a_pi[i*W +: W] = opa[i];
            b_pi[i*W +: W] = opb[i];
        end
    endtask

    task automatic cyc();
        @(posedge clk_pi);
        #1;
        for (int i = 0; i < N; i++) begin
            if (gnt_po[i] === 1'b1 && !keep) pend[i] = 1'b0;
        end
        drive();
    endtask

    task automatic issue(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        pend[i] = 1'b1; opa[i] = a; opb[i] = b;
        drive();
    endtask

    task automatic do_reset();
        rst_pi = 1'b1;
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        drive();
        cyc(); cyc();
        rst_pi = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin : stim
        int r0;
        int g0;
        for (int i = 0; i < N; i++) begin pend[i] = 1'b1; opa[i] = '0; opb[i] = '0; end
        rst_pi = 1'b1; result_ready_pi = 1'b1;
        drive();
        // Reset held two cycles with every request raised.
        cyc(); cyc();
        check("t1_busy", busy_po, 0);
        check("t1_gnt", gnt_po, 0);
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        rst_pi = 1'b0;
        drive();
        run(2);

        r0 = n_results;
        issue(2, 8'h3C, 8'h15);
        run(6);
        check("t2_count", n_results - r0, 1);
        check("t2_sum", last_sum, 8'h51);
        check("t2_carry", last_carry, 0);
        check("t2_id", last_id, 2);

        issue(0, 8'hFF, 8'h01);
        run(6);
        check("t3a_sum", last_sum, 8'h00);
        check("t3a_carry", last_carry, 1);
        issue(0, 8'h80, 8'h80);
        run(6);
        check("t3b_sum", last_sum, 8'h00);
        check("t3b_carry", last_carry, 1);
        check("t3b_id", last_id, 0);

        // Fairness from a fresh pointer with every request held.
        do_reset();
        gnt_log.delete(); gnt_cyc.delete();
        keep = 1'b1;
        for (int i = 0; i < N; i++) issue(i, W'($urandom), W'($urandom));
        run(18);
        keep = 1'b0;
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        drive();
        run(4);
        check("t4_ngrants", gnt_log.size(), 6);
        if (gnt_log.size() >= 6) begin
            for (int k = 0; k < 6; k++) begin
                check("t4_order", gnt_log[k], k % N);
                if (k > 0) check("t4_spacing", gnt_cyc[k] - gnt_cyc[k-1], 3);
            end
        end

        // Backpressure with other requests pending.
        result_ready_pi = 1'b0;
        issue(1, 8'h11, 8'h22);
        issue(3, 8'hF0, 8'h20);
        for (int t = 0; t < 10 && result_valid_po !== 1'b1; t++) cyc();
        check("t5_valid_seen", result_valid_po, 1);
        g0 = gnt_log.size();
        for (int t = 0; t < 5; t++) begin
            cyc();
            check("t5_hold_valid", result_valid_po, 1);
            check("t5_hold_busy", busy_po, 1);
        end
        check("t5_no_grant", gnt_log.size(), g0);
        result_ready_pi = 1'b1;
        cyc(); cyc();
        check("t5_next_gnt", gnt_po, 4'b0010);
        run(6);

        // Reset arriving at the edge after a grant.
        for (int i = 0; i < N; i++) issue(i, W'($urandom), W'($urandom));
        for (int t = 0; t < 10 && gnt_po == '0; t++) cyc();
        check("t6_gnt_seen", gnt_po != '0, 1);
        rst_pi = 1'b1;
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        drive();
        cyc();
        rst_pi = 1'b0;
        for (int t = 0; t < 4; t++) begin
            cyc();
            check("t6_no_valid", result_valid_po, 0);
        end
        for (int i = 0; i < N; i++) issue(i, W'($urandom), W'($urandom));
        for (int t = 0; t < 5 && gnt_po == '0; t++) cyc();
        check("t6_first_gnt", gnt_po, 4'b0001);
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        drive();
        run(6);

        // Random traffic with random backpressure.
        for (int t = 0; t < 400; t++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 3) == 0) issue(i, W'($urandom), W'($urandom));
            end
            result_ready_pi = ($urandom_range(0, 3) != 0);
            cyc();
        end
        result_ready_pi = 1'b1;
        run(40);
        check("end_sb_empty", sb_q.size(), 0);
        check("end_idle", busy_po, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
